fib_ram_sequencer: RTL and testbench

Controller that fills an external simple dual-port RAM with Fibonacci terms F(0)..F(N-1). Port A is write, port B is read with 1-cycle registered-output latency. Each new term is computed by reading the two previous terms back from RAM, adding them and writing the sum. When the block is idle, a host read port shares RAM port B, so the table can be dumped after a run.

---
 rtl/fib_ram_sequencer.sv | 169 ++++++++++++++++
 tb/tb_fib_ram_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fib_ram_sequencer.sv
// fib_ram_sequencer
//
// Fills an external simple dual-port RAM with Fibonacci terms F(0)..F(N-1).
// Port A writes. Port B reads, and its output is registered, so data for an
// address presented in cycle c appears on ram_doutb in cycle c+1. Each new term
// is produced by reading back the two previous terms, adding them and writing
// the sum. While idle, a host read port shares RAM port B so that the table can
// be dumped after a run.
//
// Ports
//   clk, rst_n        : clock (rising edge) and asynchronous active-low reset
//   start, n_terms    : run request and term count, sampled in IDLE only
//   busy, done        : run in progress / one-cycle end-of-run pulse
//   result, overflow  : F(N-1) of the last run / sticky carry-out of any sum
//   state             : debug view of the FSM state encoding
//   ram_wea, ram_addra, ram_dina : RAM write port
//   ram_addrb, ram_doutb         : RAM read port (1-cycle latency)
//   host_rd, host_addr           : host read request (honoured in IDLE only)
//   host_rvalid, host_rdata      : host read response, one cycle after request
//
// Handshake: a host read is accepted in any IDLE cycle where host_rd=1 and
// start=0. Exactly one cycle later host_rvalid=1 with host_rdata valid; there
// is no back-pressure, so back-to-back reads give one response per cycle.
// host_rdata is forced to 0 whenever host_rvalid is 0.

module fib_ram_sequencer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   n_terms,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              overflow,
  output logic [2:0]        state,
  output logic              ram_wea,
  output logic [ADDR_W-1:0] ram_addra,
  output logic [DATA_W-1:0] ram_dina,
  output logic [ADDR_W-1:0] ram_addrb,
  input  logic [DATA_W-1:0] ram_doutb,
  input  logic              host_rd,
  input  logic [ADDR_W-1:0] host_addr,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT0 = 3'd1,
    S_INIT1 = 3'd2,
    S_RD0   = 3'd3,
    S_RD1   = 3'd4,
    S_WR    = 3'd5,
    S_FIN   = 3'd6
  } state_t;

  localparam logic [ADDR_W:0] N_MAX   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] N_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] N_TWO   = (ADDR_W+1)'(2);
  localparam logic [ADDR_W:0] N_THREE = (ADDR_W+1)'(3);

  state_t              st;
  logic [ADDR_W:0]     n_lat;     // clamped term count of the current run
  logic [ADDR_W-1:0]   idx;       // index i of the term being produced
  logic [DATA_W-1:0]   op_a;      // mem[i-2], captured at the end of RD1
  logic [DATA_W-1:0]   result_q;
  logic                ovf_q;
  logic                rvalid_q;

  logic [ADDR_W:0]     n_clamped;
  logic [DATA_W:0]     sum;
  logic                last_term;
  logic                host_go;

  assign n_clamped = (n_terms > N_MAX) ? N_MAX : n_terms;
  // In WR, ram_doutb carries mem[i-1] (address presented during RD1).
  assign sum       = {1'b0, op_a} + {1'b0, ram_doutb};
  assign last_term = ({1'b0, idx} == (n_lat - N_ONE));
  // start has priority over a simultaneous host read.
  assign host_go   = (st == S_IDLE) && host_rd && !start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= S_IDLE;
      n_lat    <= '0;
      idx      <= '0;
      op_a     <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= host_go;
      case (st)
        S_IDLE: begin
          if (start) begin
            n_lat    <= n_clamped;
            idx      <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            st       <= (n_clamped >= N_ONE) ? S_INIT0 : S_FIN;
          end
        end
        S_INIT0: st <= (n_lat >= N_TWO) ? S_INIT1 : S_FIN;
        S_INIT1: begin
          idx      <= ADDR_W'(2);
          // F(1) is the answer when the run stops here (N=2).
          result_q <= DATA_W'(1);
          st       <= (n_lat >= N_THREE) ? S_RD0 : S_FIN;
        end
        S_RD0: st <= S_RD1;
        S_RD1: begin
          op_a <= ram_doutb;
          st   <= S_WR;
        end
        S_WR: begin
          result_q <= sum[DATA_W-1:0];
          if (sum[DATA_W]) ovf_q <= 1'b1;
          if (last_term) begin
            st <= S_FIN;
          end else begin
            idx <= idx + ADDR_W'(1);
            st  <= S_RD0;
          end
        end
        S_FIN:   st <= S_IDLE;
        default: st <= S_IDLE;
      endcase
    end
  end

  // RAM port drive is decoded from the registered state so writes can only
  // ever occur in INIT0, INIT1 and WR.
  always_comb begin
    ram_wea   = 1'b0;
    ram_addra = '0;
    ram_dina  = '0;
    ram_addrb = '0;
    case (st)
      S_IDLE:  if (host_go) ram_addrb = host_addr;
      S_INIT0: ram_wea = 1'b1;
      S_INIT1: begin
        ram_wea   = 1'b1;
        ram_addra = ADDR_W'(1);
        ram_dina  = DATA_W'(1);
      end
      S_RD0:   ram_addrb = idx - ADDR_W'(2);
      S_RD1:   ram_addrb = idx - ADDR_W'(1);
      S_WR: begin
        ram_wea   = 1'b1;
        ram_addra = idx;
        ram_dina  = sum[DATA_W-1:0];
      end
      default: ;
    endcase
  end

  assign busy        = (st == S_INIT0) || (st == S_INIT1) || (st == S_RD0) ||
                       (st == S_RD1) || (st == S_WR);
  assign done        = (st == S_FIN);
  assign state       = st;
  assign result      = result_q;
  assign overflow    = ovf_q;
  assign host_rvalid = rvalid_q;
  assign host_rdata  = rvalid_q ? ram_doutb : '0;

endmodule

// File: tb/tb_fib_ram_sequencer.sv
module tb_fib_ram_sequencer;

  localparam int DW = 32;
  localparam int AW = 6;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW:0]   n_terms;
  logic          busy, done, overflow, ram_wea, host_rvalid;
  logic [DW-1:0] result, ram_dina, ram_doutb, host_rdata;
  logic [2:0]    state;
  logic [AW-1:0] ram_addra, ram_addrb, host_addr;
  logic          host_rd;

  fib_ram_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_terms(n_terms),
    .busy(busy), .done(done), .result(result), .overflow(overflow),
    .state(state), .ram_wea(ram_wea), .ram_addra(ram_addra),
    .ram_dina(ram_dina), .ram_addrb(ram_addrb), .ram_doutb(ram_doutb),
    .host_rd(host_rd), .host_addr(host_addr), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple dual-port RAM with registered read output.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_wea) mem[ram_addra] <= ram_dina;
    ram_doutb <= mem[ram_addrb];
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] exp_res_q[$];
  logic          exp_ovf_q[$];
  logic [DW-1:0] exp_host_q[$];
  int exp_dones = 0;

  int busy_cnt, wr_cnt, rv_cnt, done_cnt;
  logic [AW-1:0] max_wa, last_wa;
  logic [DW-1:0] last_wd;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: event seen, none expected", name);
  endtask

  // ---------------- monitor ----------------
  initial begin
    busy_cnt = 0; wr_cnt = 0; rv_cnt = 0; done_cnt = 0;
    max_wa = '0; last_wa = '0; last_wd = '0;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) busy_cnt++;
      if (ram_wea) begin
        wr_cnt++;
        last_wa = ram_addra;
        last_wd = ram_dina;
        if (ram_addra > max_wa) max_wa = ram_addra;
      end
      if (host_rvalid) begin
        rv_cnt++;
        if (exp_host_q.size() == 0) fail("unexpected host_rvalid");
        else check("host_rdata", host_rdata, exp_host_q.pop_front());
      end else begin
        check("host_rdata idle zero", host_rdata, 0);
      end
      if (done) begin
        done_cnt++;
        if (exp_res_q.size() == 0) fail("unexpected done");
        else begin
          check("result", result, exp_res_q.pop_front());
          check("overflow", overflow, exp_ovf_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic expect_run(input logic [DW-1:0] r, input logic o);
    exp_res_q.push_back(r);
    exp_ovf_q.push_back(o);
    exp_dones++;
  endtask

  task automatic start_run(input int n);
    @(posedge clk); #1;
    start = 1'b1;
    n_terms = (AW+1)'(n);
    busy_cnt = 0; wr_cnt = 0; rv_cnt = 0;
    max_wa = '0; last_wa = '0; last_wd = '0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Returns the number of cycles after the start edge at which done is seen.
  task automatic wait_done(input int limit, output int lat);
    lat = 0;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) begin
      n_checks++; n_errors++;
      $display("FAIL done timeout: got none expected done within %0d cycles", limit);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  int lat;
  int found;
  logic [DW-1:0] fib10 [0:9];

  initial begin
    fib10 = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd3, 32'd5, 32'd8, 32'd13, 32'd21, 32'd34};
    rst_n = 1'b0; start = 1'b0; n_terms = '0; host_rd = 1'b0; host_addr = '0;
    repeat (3) @(negedge clk);
    check("reset state", state, 0);
    check("reset outputs", {busy, done, overflow, ram_wea, host_rvalid}, 0);
    check("reset data", {result, ram_dina, ram_addra, ram_addrb}, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // N=10
    expect_run(32'd34, 1'b0);
    start_run(10);
    wait_done(100, lat);
    check("n10 busy cycles", busy_cnt, 26);
    check("n10 done latency", lat, 27);
    check("n10 write count", wr_cnt, 10);

    // Host dump, back-to-back reads
    rv_cnt = 0;
    for (int a = 0; a < 10; a++) begin
      @(posedge clk); #1;
      host_rd = 1'b1;
      host_addr = AW'(a);
      exp_host_q.push_back(fib10[a]);
    end
    @(posedge clk); #1 host_rd = 1'b0;
    @(posedge clk); #1;
    check("host read count", rv_cnt, 10);
    check("host queue drained", exp_host_q.size(), 0);

    // N=48, largest run without overflow
    expect_run(32'd2971215073, 1'b0);
    start_run(48);
    wait_done(300, lat);
    check("n48 done latency", lat, 141);

    // N=49 overflows
    expect_run(32'd512559680, 1'b1);
    start_run(49);
    wait_done(300, lat);

    // N=0: straight to FIN, no writes, overflow cleared
    expect_run(32'd0, 1'b0);
    start_run(0);
    wait_done(10, lat);
    check("n0 done latency", lat, 1);
    check("n0 write count", wr_cnt, 0);

    // N=1: single write of 0 to address 0
    expect_run(32'd0, 1'b0);
    start_run(1);
    wait_done(10, lat);
    check("n1 done latency", lat, 2);
    check("n1 write count", wr_cnt, 1);
    check("n1 write addr/data", {last_wa, last_wd}, 0);

    // N=100 clamps to 64; start and host_rd during busy are ignored
    expect_run(32'd3350226146, 1'b1);
    start_run(100);
    repeat (5) @(posedge clk);
    #1 start = 1'b1; n_terms = 7'd3;
    @(posedge clk); #1 start = 1'b0;
    host_rd = 1'b1; host_addr = 6'd5;
    repeat (6) @(posedge clk);
    #1 host_rd = 1'b0;
    wait_done(400, lat);
    check("n100 last write addr", max_wa, 63);
    check("n100 write count", wr_cnt, 64);
    check("n100 host_rvalid while busy", rv_cnt, 0);
    repeat (3) @(posedge clk); #1;
    check("n100 idle after run", state, 0);
    check("n100 single done", done_cnt, exp_dones);

    // Reset during RD1 of term 20
    start_run(30);
    found = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (state == 3'd4 && ram_addrb == 6'd19) begin
        found = 1;
        break;
      end
    end
    check("reached RD1 of term 20", found, 1);
    #1 rst_n = 1'b0;
    #1;
    check("abort state", state, 0);
    check("abort outputs", {busy, done, overflow, ram_wea, host_rvalid}, 0);
    check("abort data", {result, ram_dina, ram_addra, ram_addrb}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("abort no done", done_cnt, exp_dones);

    expect_run(32'd3, 1'b0);
    start_run(5);
    wait_done(50, lat);
    check("n5 done latency", lat, 12);

    // start and host_rd in the same IDLE cycle: start wins
    expect_run(32'd1, 1'b0);
    @(posedge clk); #1;
    start = 1'b1; n_terms = 7'd3; host_rd = 1'b1; host_addr = 6'd3;
    rv_cnt = 0;
    @(posedge clk); #1;
    start = 1'b0; host_rd = 1'b0;
    @(negedge clk);
    check("start wins host_rvalid", host_rvalid, 0);
    check("start wins busy", busy, 1);
    wait_done(50, lat);
    check("start wins no host read", rv_cnt, 0);

    repeat (3) @(posedge clk); #1;
    check("result queue drained", exp_res_q.size(), 0);
    check("total done pulses", done_cnt, exp_dones);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
